// File: rtl/freq_sig_gen.sv
// freq_sig_gen: programmable square-wave source driven by a BCD frequency request.
// Ports:
//   clck        system clock, rising edge
//   rst         asynchronous active-high reset
//   freq_bcd    8-digit BCD frequency in Hz, sampled with load
//   load        one-cycle request strobe, accepted only in IDLE or RUN
//   sigout      generated square wave
//   active      high while the wave is running
//   busy        high while converting, checking or dividing
//   err         sticky illegal-request flag, cleared by the next accepted load
//   half_period current half-period in clck cycles
module freq_sig_gen #(
   parameter int unsigned CLK_HZ = 50_000_000
) (
   input  logic        clck,
   input  logic        rst,
   input  logic [31:0] freq_bcd,
   input  logic        load,
   output logic        sigout,
   output logic        active,
   output logic        busy,
   output logic        err,
   output logic [31:0] half_period
);
   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] CONV  = 3'd1;
   localparam logic [2:0] CHECK = 3'd2;
   localparam logic [2:0] DIV   = 3'd3;
   localparam logic [2:0] RUN   = 3'd4;
   localparam logic [31:0] CLKV = 32'(CLK_HZ);
   logic [2:0]  state;
   logic [31:0] bcd;
   logic [26:0] acc;
   logic        bad;
   logic [4:0]  cnt;
   logic [28:0] rem;
   logic [31:0] quo;
   logic [31:0] tick;
   logic [27:0] dsr;
   logic [26:0] acc_next;
   logic [29:0] trial;
   logic        ge;
   logic        accept;
   assign dsr      = {acc, 1'b0};
   // acc*10 as (acc<<3)+(acc<<1); cannot overflow for legal digit strings
   assign acc_next = {acc[23:0], 3'b0} + {acc[25:0], 1'b0} + {23'b0, bcd[31:28]};
   // restoring division step: shift the next dividend bit into the remainder
   assign trial    = {rem, quo[31]};
   assign ge       = trial >= {2'b0, dsr};
   assign accept   = load && (state == IDLE || state == RUN);
   assign active   = state == RUN;
   assign busy     = state == CONV || state == CHECK || state == DIV;
   always_ff @(posedge clck or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         bcd         <= '0;
         acc         <= '0;
         bad         <= 1'b0;
         cnt         <= '0;
         rem         <= '0;
         quo         <= '0;
         tick        <= '0;
         sigout      <= 1'b0;
         err         <= 1'b0;
         half_period <= '0;
      end else if (accept) begin
         // a new request always wins over a coincident RUN toggle
         state  <= CONV;
         bcd    <= freq_bcd;
         acc    <= '0;
         bad    <= 1'b0;
         cnt    <= '0;
         err    <= 1'b0;
         sigout <= 1'b0;
      end else begin
         case (state)
            CONV: begin
               if (cnt == 5'd8) begin
                  state <= CHECK;
               end else begin
                  acc <= acc_next;
                  bad <= bad | (bcd[31:28] > 4'd9);
                  bcd <= {bcd[27:0], 4'h0};
                  cnt <= cnt + 5'd1;
               end
            end
            CHECK: begin
               if (bad || acc == '0 || {4'b0, dsr} > CLKV) begin
                  state  <= IDLE;
                  err    <= 1'b1;
                  sigout <= 1'b0;
               end else begin
                  state <= DIV;
                  rem   <= '0;
                  quo   <= CLKV;
                  cnt   <= '0;
               end
            end
            DIV: begin
               rem <= ge ? 29'(trial - {2'b0, dsr}) : trial[28:0];
               quo <= {quo[30:0], ge};
               cnt <= cnt + 5'd1;
               if (cnt == 5'd31) begin
                  half_period <= {quo[30:0], ge};
                  tick        <= '0;
                  state       <= RUN;
               end
            end
            RUN: begin
               if (tick == half_period - 32'd1) begin
                  sigout <= ~sigout;
                  tick   <= '0;
               end else begin
                  tick <= tick + 32'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
